bitwise_eco_pipe: RTL and testbench



---
 rtl/bitwise_eco_pipe.sv | 218 +++++++++++++++++++++
 tb/tb_bitwise_eco_pipe.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitwise_eco_pipe.sv
// ---------------------------------------------------------------------------
// bitwise_eco_pipe
//
// Pipelined per-bit logic unit with a runtime-programmable correction term.
// Computes y = f_op(a, b) ^ (eco_mask & t_sel), and the number of ones in y,
// through a two-stage valid/ready pipeline (S1 holds operands and a snapshot
// of the configuration, S2 holds the result).
//
// Parameters
//   WIDTH         operand/result width (>= 1)
//   CW            width of the ones count, derived as $clog2(WIDTH+1)
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   in_valid      operand transfer request
//   in_ready      unit can accept operands (does not depend on in_valid)
//   in_a, in_b    operands
//   in_op         function select: 0 NOR, 1 OR, 2 AND, 3 NAND,
//                 4 XOR, 5 XNOR, 6 ANDN (a & ~b), 7 PASS_A
//   cfg_we        load cfg_eco_mask / cfg_eco_sel on this clock edge
//   cfg_eco_mask  bits that receive the correction term
//   cfg_eco_sel   correction term source: 0 ~a, 1 a, 2 b, 3 ~b
//   out_valid     result available
//   out_ready     consumer accepts result
//   out_y         result
//   out_ones      number of ones in out_y
//   out_op        in_op that produced this result
// ---------------------------------------------------------------------------
module bitwise_eco_pipe #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             cfg_we,
    input  logic [WIDTH-1:0] cfg_eco_mask,
    input  logic [1:0]       cfg_eco_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic [CW-1:0]    out_ones,
    output logic [2:0]       out_op
);

    localparam logic [2:0] OP_NOR    = 3'd0;
    localparam logic [2:0] OP_OR     = 3'd1;
    localparam logic [2:0] OP_AND    = 3'd2;
    localparam logic [2:0] OP_NAND   = 3'd3;
    localparam logic [2:0] OP_XOR    = 3'd4;
    localparam logic [2:0] OP_XNOR   = 3'd5;
    localparam logic [2:0] OP_ANDN   = 3'd6;
    localparam logic [2:0] OP_PASS_A = 3'd7;

    localparam logic [1:0] SEL_NOT_A = 2'd0;
    localparam logic [1:0] SEL_A     = 2'd1;
    localparam logic [1:0] SEL_B     = 2'd2;
    localparam logic [1:0] SEL_NOT_B = 2'd3;

    // configuration registers
    logic [WIDTH-1:0] eco_mask_q, eco_mask_d;
    logic [1:0]       eco_sel_q,  eco_sel_d;

    // stage 1: operands plus configuration snapshot
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q,     s1_a_d;
    logic [WIDTH-1:0] s1_b_q,     s1_b_d;
    logic [2:0]       s1_op_q,    s1_op_d;
    logic [WIDTH-1:0] s1_mask_q,  s1_mask_d;
    logic [1:0]       s1_sel_q,   s1_sel_d;

    // stage 2: result
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_y_q,     out_y_d;
    logic [CW-1:0]    out_ones_q,  out_ones_d;
    logic [2:0]       out_op_q,    out_op_d;

    // handshake
    logic s2_adv;
    logic s1_adv;
    logic in_acc;

    // S1 -> S2 datapath
    logic [WIDTH-1:0] base_c;
    logic [WIDTH-1:0] term_c;
    logic [WIDTH-1:0] y_c;
    logic [CW-1:0]    ones_c;

    always_comb begin
        s2_adv   = !out_valid_q || out_ready;
        s1_adv   = s1_valid_q && s2_adv;
        in_ready = !s1_valid_q || s2_adv;
        in_acc   = in_valid && in_ready;
    end

    always_comb begin
        base_c = '0;
        case (s1_op_q)
            OP_NOR:    base_c = ~(s1_a_q | s1_b_q);
            OP_OR:     base_c =   s1_a_q | s1_b_q;
            OP_AND:    base_c =   s1_a_q & s1_b_q;
            OP_NAND:   base_c = ~(s1_a_q & s1_b_q);
            OP_XOR:    base_c =   s1_a_q ^ s1_b_q;
            OP_XNOR:   base_c = ~(s1_a_q ^ s1_b_q);
            OP_ANDN:   base_c =   s1_a_q & ~s1_b_q;
            OP_PASS_A: base_c =   s1_a_q;
            default:   base_c = '0;
        endcase
    end

    always_comb begin
        term_c = '0;
        case (s1_sel_q)
            SEL_NOT_A: term_c = ~s1_a_q;
            SEL_A:     term_c =  s1_a_q;
            SEL_B:     term_c =  s1_b_q;
            SEL_NOT_B: term_c = ~s1_b_q;
            default:   term_c = '0;
        endcase
    end

    // CW is sized for WIDTH+1 values, so a fully set result never wraps.
    always_comb begin
        y_c    = base_c ^ (s1_mask_q & term_c);
        ones_c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones_c = ones_c + CW'(y_c[i]);
        end
    end

    // A transfer accepted on the same edge as a cfg write snapshots the old
    // register contents, since both updates happen on that one edge.
    always_comb begin
        eco_mask_d = eco_mask_q;
        eco_sel_d  = eco_sel_q;
        if (cfg_we) begin
            eco_mask_d = cfg_eco_mask;
            eco_sel_d  = cfg_eco_sel;
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        s1_mask_d  = s1_mask_q;
        s1_sel_d   = s1_sel_q;
        if (in_acc) begin
            s1_valid_d = 1'b1;
            s1_a_d     = in_a;
            s1_b_d     = in_b;
            s1_op_d    = in_op;
            s1_mask_d  = eco_mask_q;
            s1_sel_d   = eco_sel_q;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    // When S2 may advance but S1 is empty, out_valid drops and the data
    // registers keep their last value.
    always_comb begin
        out_valid_d = out_valid_q;
        out_y_d     = out_y_q;
        out_ones_d  = out_ones_q;
        out_op_d    = out_op_q;
        if (s2_adv) begin
            out_valid_d = s1_valid_q;
        end
        if (s1_adv) begin
            out_y_d    = y_c;
            out_ones_d = ones_c;
            out_op_d   = s1_op_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eco_mask_q  <= '0;
            eco_sel_q   <= '0;
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_op_q     <= '0;
            s1_mask_q   <= '0;
            s1_sel_q    <= '0;
            out_valid_q <= 1'b0;
            out_y_q     <= '0;
            out_ones_q  <= '0;
            out_op_q    <= '0;
        end else begin
            eco_mask_q  <= eco_mask_d;
            eco_sel_q   <= eco_sel_d;
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_op_q     <= s1_op_d;
            s1_mask_q   <= s1_mask_d;
            s1_sel_q    <= s1_sel_d;
            out_valid_q <= out_valid_d;
            out_y_q     <= out_y_d;
            out_ones_q  <= out_ones_d;
            out_op_q    <= out_op_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_y     = out_y_q;
    assign out_ones  = out_ones_q;
    assign out_op    = out_op_q;

endmodule

// File: tb/tb_bitwise_eco_pipe.sv
// ---------------------------------------------------------------------------
// tb_bitwise_eco_pipe
//
// Self-checking bench for bitwise_eco_pipe. A WIDTH=8 instance is driven by
// directed scenarios and random traffic and compared against a truth-table
// reference model with a result queue; a WIDTH=7 instance covers the ones
// count at its upper boundary.
// ---------------------------------------------------------------------------
module tb_bitwise_eco_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       in_valid, in_ready;
    logic [7:0] in_a, in_b;
    logic [2:0] in_op;
    logic       cfg_we;
    logic [7:0] cfg_eco_mask;
    logic [1:0] cfg_eco_sel;
    logic       out_valid, out_ready;
    logic [7:0] out_y;
    logic [3:0] out_ones;
    logic [2:0] out_op;

    logic       v7, r7, ov7;
    logic [6:0] a7, b7, y7;
    logic [2:0] op7, oop7;
    logic [2:0] ones7;

    bitwise_eco_pipe #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .cfg_we(cfg_we), .cfg_eco_mask(cfg_eco_mask), .cfg_eco_sel(cfg_eco_sel),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_ones(out_ones), .out_op(out_op)
    );

    bitwise_eco_pipe #(.WIDTH(7)) dut7 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v7), .in_ready(r7),
        .in_a(a7), .in_b(b7), .in_op(op7),
        .cfg_we(1'b0), .cfg_eco_mask(7'h00), .cfg_eco_sel(2'd0),
        .out_valid(ov7), .out_ready(1'b1),
        .out_y(y7), .out_ones(ones7), .out_op(oop7)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // truth table per op, indexed by {a_bit, b_bit}
    logic [3:0] tt [8] = '{4'b0001, 4'b1110, 4'b1000, 4'b0111,
                           4'b0110, 4'b1001, 4'b0100, 4'b1100};

    function automatic logic [7:0] model_y(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] op, input logic [7:0] mask,
                                           input logic [1:0] sel);
        logic [7:0] y;
        logic       t;
        logic [3:0] row;
        row = tt[op];
        for (int i = 0; i < 8; i++) begin
            case (sel)
                2'd0:    t = ~a[i];
                2'd1:    t =  a[i];
                2'd2:    t =  b[i];
                default: t = ~b[i];
            endcase
            y[i] = row[{a[i], b[i]}] ^ (mask[i] & t);
        end
        return y;
    endfunction

    function automatic int count_ones(input logic [7:0] v);
        int n = 0;
        for (int i = 0; i < 8; i++) if (v[i]) n++;
        return n;
    endfunction

    typedef struct {
        logic [7:0] y;
        int         ones;
        logic [2:0] op;
        bit         chk_c;
        logic [7:0] cy;
        int         cones;
        bit         chk_lat;
        int         acc_cyc;
    } exp_t;

    exp_t sb[$];

    logic [7:0] m_mask = 8'h00;
    logic [1:0] m_sel  = 2'd0;
    bit         d_chk  = 0;
    logic [7:0] d_cy   = 8'h00;
    int         d_cones = 0;
    bit         d_lat  = 0;
    int         cyc    = 0;
    bit         acc_flag;

    // One clock cycle: entered at a negedge with inputs already set.
    task automatic cycle();
        exp_t pe;
        exp_t ne;
        #1;
        acc_flag = in_valid && in_ready;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check_val("spurious_out", 1, 0);
            end else begin
                pe = sb.pop_front();
                check_val("y", 32'(out_y), 32'(pe.y));
                check_val("ones", 32'(out_ones), pe.ones);
                check_val("op", 32'(out_op), 32'(pe.op));
                if (pe.chk_c) begin
                    check_val("y_const", 32'(out_y), 32'(pe.cy));
                    check_val("ones_const", 32'(out_ones), pe.cones);
                end
                if (pe.chk_lat) check_val("latency", cyc - pe.acc_cyc, 2);
            end
        end
        if (acc_flag) begin
            ne.y       = model_y(in_a, in_b, in_op, m_mask, m_sel);
            ne.ones    = count_ones(ne.y);
            ne.op      = in_op;
            ne.chk_c   = d_chk;
            ne.cy      = d_cy;
            ne.cones   = d_cones;
            ne.chk_lat = d_lat;
            ne.acc_cyc = cyc;
            sb.push_back(ne);
        end
        @(posedge clk);
        if (cfg_we) begin
            m_mask = cfg_eco_mask;
            m_sel  = cfg_eco_sel;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input bit chk, input logic [7:0] cy, input int cones, input bit lat);
        in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
        d_chk = chk; d_cy = cy; d_cones = cones; d_lat = lat;
        acc_flag = 0;
        for (int k = 0; k < 50; k++) begin
            cycle();
            if (acc_flag) break;
        end
        if (!acc_flag) check_val("send_timeout", 0, 1);
        in_valid = 1'b0;
        d_chk = 0; d_lat = 0;
    endtask

    task automatic write_cfg(input logic [7:0] mask, input logic [1:0] sel);
        cfg_eco_mask = mask; cfg_eco_sel = sel; cfg_we = 1'b1;
        cycle();
        cfg_we = 1'b0;
    endtask

    task automatic drain();
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 20 && sb.size() != 0; k++) cycle();
        if (sb.size() != 0) check_val("drain_timeout", sb.size(), 0);
        cycle();
    endtask

    logic [7:0] ops_exp [8] = '{8'h02, 8'hFD, 8'h04, 8'hFB,
                                8'hF9, 8'h06, 8'hC1, 8'hC5};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [7:0] hold_y;
        rst_n = 1'b0;
        in_valid = 0; in_a = 0; in_b = 0; in_op = 0;
        cfg_we = 0; cfg_eco_mask = 0; cfg_eco_sel = 0; out_ready = 1;
        v7 = 0; a7 = 0; b7 = 0; op7 = 0;
        #3;
        check_val("rst_out_valid", 32'(out_valid), 0);
        check_val("rst_out_y", 32'(out_y), 0);
        check_val("rst_out_ones", 32'(out_ones), 0);
        check_val("rst_out_op", 32'(out_op), 0);
        check_val("rst_in_ready", 32'(in_ready), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // legacy slice equivalence
        write_cfg(8'h02, 2'd0);
        send(8'h00, 8'h00, 3'd0, 1, 8'hFD, 7, 1);
        send(8'h02, 8'h00, 3'd0, 1, 8'hFD, 7, 1);
        send(8'h00, 8'h02, 3'd0, 1, 8'hFF, 8, 1);
        drain();

        // every op, no correction
        write_cfg(8'h00, 2'd0);
        for (int op = 0; op < 8; op++) begin
            send(8'hC5, 8'h3C, 3'(op), 1, ops_exp[op], count_ones(ops_exp[op]), 1);
        end
        drain();

        // backpressure
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 8'h11; in_b = 8'h22; in_op = 3'd1;
        cycle();
        check_val("bp_acc1", 32'(acc_flag), 1);
        in_a = 8'h33; in_b = 8'h0F; in_op = 3'd4;
        cycle();
        check_val("bp_acc2", 32'(acc_flag), 1);
        in_a = 8'h55; in_b = 8'hF0; in_op = 3'd2;
        hold_y = model_y(8'h11, 8'h22, 3'd1, 8'h00, 2'd0);
        for (int k = 0; k < 4; k++) begin
            cycle();
            check_val("bp_no_acc", 32'(acc_flag), 0);
            check_val("bp_in_ready", 32'(in_ready), 0);
            check_val("bp_out_valid", 32'(out_valid), 1);
            check_val("bp_hold_y", 32'(out_y), 32'(hold_y));
        end
        out_ready = 1'b1;
        cycle();
        check_val("bp_acc3", 32'(acc_flag), 1);
        in_valid = 1'b0;
        check_val("bp_burst2", 32'(out_valid), 1);
        cycle();
        check_val("bp_burst3", 32'(out_valid), 1);
        drain();

        // config write racing a transfer
        in_valid = 1'b1; in_a = 8'h0F; in_b = 8'h00; in_op = 3'd1;
        cfg_eco_mask = 8'hFF; cfg_eco_sel = 2'd1; cfg_we = 1'b1;
        d_chk = 1; d_cy = 8'h0F; d_cones = 4; d_lat = 1;
        cycle();
        check_val("race_acc", 32'(acc_flag), 1);
        cfg_we = 1'b0; in_valid = 1'b0; d_chk = 0; d_lat = 0;
        send(8'h0F, 8'h00, 3'd1, 1, 8'h00, 0, 1);
        drain();

        // reset with both stages full
        out_ready = 1'b0;
        send(8'hA5, 8'h5A, 3'd4, 0, 8'h00, 0, 0);
        send(8'h3C, 8'hC3, 3'd2, 0, 8'h00, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("midrst_out_valid", 32'(out_valid), 0);
        check_val("midrst_in_ready", 32'(in_ready), 1);
        sb.delete();
        m_mask = 8'h00; m_sel = 2'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cycle();
            check_val("postrst_quiet", 32'(out_valid), 0);
        end
        check_val("postrst_in_ready", 32'(in_ready), 1);
        send(8'h0F, 8'h00, 3'd1, 1, 8'h0F, 4, 1);
        drain();

        // random traffic
        for (int k = 0; k < 400; k++) begin
            in_valid     = 1'($urandom_range(0, 1));
            in_a         = 8'($urandom);
            in_b         = 8'($urandom);
            in_op        = 3'($urandom_range(0, 7));
            cfg_we       = ($urandom_range(0, 7) == 0);
            cfg_eco_mask = 8'($urandom);
            cfg_eco_sel  = 2'($urandom_range(0, 3));
            out_ready    = ($urandom_range(0, 3) != 0);
            cycle();
        end
        cfg_we = 1'b0;
        drain();

        // ones count at WIDTH = 2^k - 1
        a7 = 7'h7F; b7 = 7'h00; op7 = 3'd1; v7 = 1'b1;
        @(negedge clk);
        v7 = 1'b0;
        @(negedge clk);
        check_val("w7_valid_full", 32'(ov7), 1);
        check_val("w7_y_full", 32'(y7), 32'h7F);
        check_val("w7_ones_full", 32'(ones7), 7);
        a7 = 7'h00; b7 = 7'h00; v7 = 1'b1;
        @(negedge clk);
        v7 = 1'b0;
        @(negedge clk);
        check_val("w7_valid_zero", 32'(ov7), 1);
        check_val("w7_ones_zero", 32'(ones7), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
